pipelined_adder_sub: RTL

- Parametrised WIDTH-bit adder/subtractor, the multi-bit pipelined successor of the team's single-bit full-adder cell.
- Splits the operands into STAGES equal slices and resolves one slice per clock.
- Each stage is a ripple of full adders; the carry is registered between stages.
- Valid/ready handshake on input and output, so it drops into streaming datapaths with backpressure.

---
 rtl/pipelined_adder_sub.sv | 127 ++++++++++++
 1 files changed

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit adder/subtractor: STAGES ripple-carry slices with a registered carry
// between slices and a valid/ready handshake with a single global advance enable.
module pipelined_adder_sub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SLICE = WIDTH / STAGES;

  logic adv;

  // Per-stage registers: operands carried forward, partial sum, carry-out, valid.
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [STAGES-1:0] c_q, v_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] c_d, v_d;
  logic              ovf_d;

  // Inputs seen by each stage: conditioned ports for stage 0, previous registers otherwise.
  logic [WIDTH-1:0]  a_in [STAGES];
  logic [WIDTH-1:0]  b_in [STAGES];
  logic [WIDTH-1:0]  s_in [STAGES];
  logic [STAGES-1:0] c_in, v_in;

  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];
  assign ovf       = ovf_q;

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      a_in[k] = '0;
      b_in[k] = '0;
      s_in[k] = '0;
    end
    c_in = '0;
    v_in = '0;
    // Subtraction is a + ~b + 1, so cin is overridden by the forced carry.
    a_in[0] = a;
    b_in[0] = sub ? ~b : b;
    c_in[0] = sub | cin;
    v_in[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      s_in[k] = s_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
    end
  end

  always_comb begin
    logic [WIDTH-1:0] si;
    logic             ci;
    logic             cmsb;
    int               idx;
    si    = '0;
    ci    = 1'b0;
    cmsb  = 1'b0;
    idx   = 0;
    ovf_d = 1'b0;
    c_d   = '0;
    v_d   = '0;
    for (int k = 0; k < STAGES; k++) begin
      si = s_in[k];
      ci = c_in[k];
      for (int j = 0; j < SLICE; j++) begin
        idx     = k * SLICE + j;
        cmsb    = ci;
        si[idx] = a_in[k][idx] ^ b_in[k][idx] ^ ci;
        ci      = (a_in[k][idx] & b_in[k][idx]) | (ci & (a_in[k][idx] ^ b_in[k][idx]));
      end
      a_d[k] = a_in[k];
      b_d[k] = b_in[k];
      s_d[k] = si;
      c_d[k] = ci;
      v_d[k] = v_in[k];
    end
    // After the last slice cmsb is the carry into the MSB and ci the carry out of it.
    ovf_d = cmsb ^ ci;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
      c_q   <= '0;
      v_q   <= '0;
      ovf_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
      c_q   <= c_d;
      v_q   <= v_d;
      ovf_q <= ovf_d;
    end
  end

endmodule
